// File: rtl/mem_data_port.sv
// Memory-side datapath front end: owns MAR/MDR and runs req/ack read/write
// transactions to word memory, aborting on a wait-state timeout.
module mem_data_port #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              start_read,
    input  logic              start_write,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mdr_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  mar;
    logic [DATA_W-1:0]  mdr;
    logic [CNT_W-1:0]   wait_cnt;
    logic               in_xfer;
    logic               start_any;
    logic               expire;

    assign in_xfer   = (state == READ) || (state == WRITE);
    assign start_any = start_read || start_write;
    // Ack on the final wait edge still wins over the abort.
    assign expire    = in_xfer && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; read has priority when both starts are raised
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_read) begin
                    state_next = READ;
                end else if (start_write) begin
                    state_next = WRITE;
                end
            end
            READ, WRITE: begin
                if (mem_ack || expire) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded purely from the state register: no ack-to-req path
    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            READ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
            end
            WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                busy    = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // MAR/MDR, wait counter and sticky timeout flag
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            mar         <= '0;
            mdr         <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mar_in) begin
                        mar <= bus_in[ADDR_W-1:0];
                    end
                    if (mdr_in) begin
                        mdr <= bus_in;
                    end
                    if (start_any) begin
                        wait_cnt    <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                READ, WRITE: begin
                    if (mem_ack) begin
                        if (state == READ) begin
                            mdr <= mem_rdata;
                        end
                    end else if (expire) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mdr_out   = mdr;
    assign mem_wdata = mdr;
    assign mem_addr  = mar;

endmodule

// File: doc/mem_data_port.md
Name: mem_data_port

Overview:
- Memory-side front end of the datapath. Owns the MAR and the MDR.
- The MDR output drives the bus multiplexer's mdr source.
- MAR and MDR load from the shared bus under control-unit strobes.
- Runs read/write transactions to external word memory over a req/ack handshake, with a wait-state timeout, and reports busy/done/error to the control sequencer.

Parameters:
- DATA_W, 32, bus and memory word width.
- ADDR_W, 9, memory word-address width; the MAR captures bus_in[ADDR_W-1:0].
- TIMEOUT, 16, max cycles mem_req stays asserted without mem_ack before abort (≥2).

Ports:
- clock  input  1  system clock, rising edge.
- clear_n  input  1  asynchronous active-low reset.
- bus_in  input  DATA_W  shared bus value.
- mar_in  input  1  load MAR from bus_in (IDLE only).
- mdr_in  input  1  load MDR from bus_in (IDLE only).
- start_read  input  1  begin read at MAR into MDR (IDLE only).
- start_write  input  1  begin write of MDR to MAR (IDLE only).
- mem_ack  input  1  memory acknowledge.
- mem_rdata  input  DATA_W  memory read data, valid when mem_ack=1.
- mdr_out  output  DATA_W  MDR contents, to bus mux mdr source.
- mem_addr  output  ADDR_W  MAR contents.
- mem_wdata  output  DATA_W  equals MDR.
- mem_req  output  1  transaction request.
- mem_we  output  1  1 = write, 0 = read; meaningful only while mem_req=1.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle completion pulse.
- timeout_err  output  1  last transaction aborted; sticky until next start.

Behaviour:
- **Reset:** clear_n low forces, asynchronously, all of the following:
  - MAR=0, MDR=0, state=IDLE, timeout counter=0.
  - mem_req=0, mem_we=0, done=0, busy=0, timeout_err=0.
  - Reset mid-transaction drops mem_req immediately. No MDR update occurs.
- **States:** IDLE, READ, WRITE, DONE. All outputs are registered or decoded from state. No combinational path from mem_ack to mem_req.
- **IDLE:**
  - mar_in / mdr_in load on the clock edge.
  - Loads and a start on the same edge are legal. The transaction uses the newly loaded MAR/MDR, since the transaction starts the next cycle.
  - start_read → READ. start_write → WRITE. Both high → READ (read priority), and the write is dropped.
  - Any start clears timeout_err and the counter.
- **READ / WRITE:**
  - mem_req=1. mem_we=0 in READ, 1 in WRITE.
  - mar_in, mdr_in, start_* are ignored, so MAR and MDR are stable for the whole transaction.
  - On an edge with mem_ack=1:
    - READ: MDR ← mem_rdata.
    - WRITE: MDR unchanged.
    - Then → DONE.
  - On an edge with mem_ack=0: counter increments. When the counter reaches TIMEOUT-1 with ack still low → DONE, timeout_err ← 1, MDR unchanged.
  - mem_ack=1 on the timeout edge: ack wins and no error is raised.
- **DONE:** mem_req=0, done=1, busy=1. Next edge → IDLE unconditionally. Strobes in DONE are ignored.
- **Latency:**
  - Start sampled at edge k → mem_req=1 from k.
  - Zero-wait memory (ack already high) completes at edge k+1.
  - done high in cycle k+1..k+2, busy low from edge k+2.
  - Minimum start-to-start spacing: 3 cycles.
- **mem_ack outside READ/WRITE:** ignored.
- **Widths:** MAR takes the low ADDR_W bits of bus_in; upper bits are discarded. mem_addr does not wrap or increment.

Test Plan:
1. clear_n low mid-READ (mem_req=1) → mem_req, busy, done fall without a clock. MDR=0, MAR=0. After release: state IDLE, all outputs 0.
2. bus_in=0x000001F3 with mar_in, then bus_in=0xDEADBEEF with mdr_in, then start_write; ack after 3 wait cycles →
   - mem_addr=0x1F3, mem_we=1, mem_wdata=0xDEADBEEF for 4 cycles.
   - done pulses once, MDR still 0xDEADBEEF.
3. MAR=0x010, start_read, mem_ack tied high, mem_rdata=0x000000E6 → MDR=0xE6 one edge after start. done=1 for exactly one cycle. mdr_out=230 thereafter.
4. start_read with mem_ack held low, TIMEOUT=16 → mem_req high 16 cycles. timeout_err=1, done pulse, MDR unchanged. timeout_err clears on next start_read.
5. In READ, toggle mar_in/mdr_in with bus_in=0xFFFFFFFF → MAR/MDR unchanged until ack. start_read and start_write both high in IDLE → mem_we=0.
6. mem_ack rising exactly on the 16th wait edge with mem_rdata=0x12345678 → MDR=0x12345678, timeout_err=0.
